// File: rtl/clk_div_pkg.sv
// Shared types and field widths for the clock divider reconfiguration controller.
package clk_div_pkg;
  localparam int DIV_W = 5;
  localparam int DLY_W = 5;
  localparam logic [DIV_W-1:0] RESET_DIV_DEF = 5'd2;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_HOLD,
    ST_SETTLE
  } state_t;
endpackage

// File: rtl/clk_div_cnt.sv
// Loadable down-counter with zero flag; stops at zero until reloaded.
module clk_div_cnt #(
  parameter int            W       = 4,
  parameter logic [W-1:0]  RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 cnt <= RST_VAL;
    else if (load)             cnt <= load_val;
    else if (en && cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/clk_div_ctrl.sv
// Sequences divider reconfiguration: hold div_reset, wait for settle, then ack.
// Optional change counter enabled by CLK_DIV_CTRL_CHANGE_CNT_EN.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int               HOLD_CYCLES   = 4,
  parameter int               SETTLE_CYCLES = 16,
  parameter logic [DIV_W-1:0] RESET_DIV     = RESET_DIV_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_req,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_half,
  input  logic [DLY_W-1:0] cfg_dly,
  output logic             cfg_ack,
  output logic             cfg_nack,
  output logic             busy,
  output logic             div_reset,
  output logic [DIV_W-1:0] odiv,
  output logic             odivhalf,
  output logic [DLY_W-1:0] dlygl,
  output logic             ready,
  output logic [15:0]      change_count
);
  localparam int HW = $clog2(HOLD_CYCLES) + 1;
  localparam int SW = $clog2(SETTLE_CYCLES) + 1;
  localparam logic [HW-1:0] HOLD_LD   = HW'(HOLD_CYCLES - 1);
  localparam logic [SW-1:0] SETTLE_LD = SW'(SETTLE_CYCLES - 1);
  // INIT includes the cycle before the first edge, so ready rises SETTLE_CYCLES edges after release
  localparam logic [SW-1:0] INIT_LD   = SW'(SETTLE_CYCLES);

  state_t state, state_nx;
  logic hold_load, hold_en, hold_zero;
  logic settle_load, settle_en, settle_zero;
  logic ack_nx, nack_nx, take_cfg;
  logic cfg_bad, cfg_same;

  assign cfg_bad  = cfg_half && (cfg_div < 5'd2);
  assign cfg_same = ({cfg_div, cfg_half, cfg_dly} == {odiv, odivhalf, dlygl});

  clk_div_cnt #(.W(HW), .RST_VAL('0)) u_hold_cnt (
    .clk(clk), .reset(reset), .load(hold_load), .load_val(HOLD_LD),
    .en(hold_en), .zero(hold_zero)
  );

  clk_div_cnt #(.W(SW), .RST_VAL(INIT_LD)) u_settle_cnt (
    .clk(clk), .reset(reset), .load(settle_load), .load_val(SETTLE_LD),
    .en(settle_en), .zero(settle_zero)
  );

  always_comb begin
    state_nx    = state;
    hold_load   = 1'b0;
    hold_en     = 1'b0;
    settle_load = 1'b0;
    settle_en   = 1'b0;
    ack_nx      = 1'b0;
    nack_nx     = 1'b0;
    take_cfg    = 1'b0;
    case (state)
      ST_INIT: begin
        settle_en = 1'b1;
        if (settle_zero) state_nx = ST_IDLE;
      end
      ST_IDLE: begin
        if (cfg_req) begin
          if (cfg_bad)       nack_nx = 1'b1;
          else if (cfg_same) ack_nx  = 1'b1;
          else begin
            take_cfg  = 1'b1;
            hold_load = 1'b1;
            state_nx  = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        hold_en = 1'b1;
        if (hold_zero) begin
          settle_load = 1'b1;
          state_nx    = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        settle_en = 1'b1;
        if (settle_zero) begin
          ack_nx   = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_INIT;
      odiv      <= RESET_DIV;
      odivhalf  <= 1'b0;
      dlygl     <= '0;
      div_reset <= 1'b1;
      ready     <= 1'b0;
      cfg_ack   <= 1'b0;
      cfg_nack  <= 1'b0;
    end else begin
      state     <= state_nx;
      div_reset <= (state_nx == ST_HOLD);
      ready     <= (state_nx == ST_IDLE);
      cfg_ack   <= ack_nx;
      cfg_nack  <= nack_nx;
      if (take_cfg) begin
        odiv     <= cfg_div;
        odivhalf <= cfg_half;
        dlygl    <= cfg_dly;
      end
    end
  end

  assign busy = (state != ST_IDLE);

`ifdef CLK_DIV_CTRL_CHANGE_CNT_EN
  logic [15:0] chg_cnt;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) chg_cnt <= '0;
    else if (state == ST_SETTLE && settle_zero && chg_cnt != 16'hFFFF)
      chg_cnt <= chg_cnt + 16'd1;
  end
  assign change_count = chg_cnt;
`else
  assign change_count = 16'h0000;
`endif
endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl with hand-computed cycle expectations.
module tb_clk_div_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_req;
  logic [4:0]  cfg_div;
  logic        cfg_half;
  logic [4:0]  cfg_dly;
  logic        cfg_ack, cfg_nack, busy, div_reset, odivhalf, ready;
  logic [4:0]  odiv, dlygl;
  logic [15:0] change_count;

  int vecs = 0;
  int errs = 0;
  int acks;
  logic [15:0] cnt_one;

  clk_div_ctrl dut (
    .clk(clk), .reset(reset), .cfg_req(cfg_req), .cfg_div(cfg_div),
    .cfg_half(cfg_half), .cfg_dly(cfg_dly), .cfg_ack(cfg_ack),
    .cfg_nack(cfg_nack), .busy(busy), .div_reset(div_reset), .odiv(odiv),
    .odivhalf(odivhalf), .dlygl(dlygl), .ready(ready),
    .change_count(change_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [4:0] d, input logic h, input logic [4:0] y);
    cfg_req = 1'b1; cfg_div = d; cfg_half = h; cfg_dly = y;
    tick();
    cfg_req = 1'b0;
  endtask

  task automatic chk_init();
    for (int k = 1; k <= 17; k++) begin
      tick();
      chk("init_ack", {15'd0, cfg_ack}, 16'd0);
      if (k == 1)  chk("init_divrst_rel", {15'd0, div_reset}, 16'd0);
      if (k == 16) chk("init_ready_c16", {15'd0, ready}, 16'd0);
      if (k == 16) chk("init_busy_c16", {15'd0, busy}, 16'd1);
      if (k == 17) chk("init_ready_c17", {15'd0, ready}, 16'd1);
      if (k == 17) chk("init_busy_c17", {15'd0, busy}, 16'd0);
    end
  endtask

  initial begin
`ifdef CLK_DIV_CTRL_CHANGE_CNT_EN
    cnt_one = 16'd1;
`else
    cnt_one = 16'd0;
`endif
    reset = 1'b1; cfg_req = 1'b0; cfg_div = '0; cfg_half = 1'b0; cfg_dly = '0;
    tick(); tick();
    chk("rst_odiv", {11'd0, odiv}, 16'd2);
    chk("rst_odivhalf", {15'd0, odivhalf}, 16'd0);
    chk("rst_dlygl", {11'd0, dlygl}, 16'd0);
    chk("rst_divrst", {15'd0, div_reset}, 16'd1);
    chk("rst_ready", {15'd0, ready}, 16'd0);
    chk("rst_busy", {15'd0, busy}, 16'd1);
    chk("rst_ackn", {14'd0, cfg_ack, cfg_nack}, 16'd0);
    chk("rst_cnt", change_count, 16'd0);
    reset = 1'b0;
    chk_init();

    // invalid: half with div<2
    req(5'd1, 1'b1, 5'd0);
    chk("nack_c1", {14'd0, cfg_ack, cfg_nack}, 16'd1);
    chk("nack_odiv", {11'd0, odiv}, 16'd2);
    chk("nack_busy", {15'd0, busy}, 16'd0);
    tick();
    chk("nack_c2", {14'd0, cfg_ack, cfg_nack}, 16'd0);

    // same as current config
    req(5'd2, 1'b0, 5'd0);
    chk("same_ack_c1", {14'd0, cfg_ack, cfg_nack}, 16'd2);
    chk("same_divrst", {15'd0, div_reset}, 16'd0);
    chk("same_busy", {15'd0, busy}, 16'd0);
    tick();
    chk("same_divrst_c2", {15'd0, div_reset}, 16'd0);
    chk("same_cnt", change_count, 16'd0);

    // full reconfiguration sequence
    req(5'd5, 1'b0, 5'd3);
    chk("seq_odiv", {11'd0, odiv}, 16'd5);
    chk("seq_dlygl", {11'd0, dlygl}, 16'd3);
    for (int k = 1; k <= 22; k++) begin
      if (k > 1) tick();
      chk($sformatf("seq_divrst_c%0d", k), {15'd0, div_reset}, {15'd0, k <= 4});
      chk($sformatf("seq_ready_c%0d", k), {15'd0, ready}, {15'd0, k >= 21});
      chk($sformatf("seq_ack_c%0d", k), {15'd0, cfg_ack}, {15'd0, k == 21});
      chk($sformatf("seq_busy_c%0d", k), {15'd0, busy}, {15'd0, k <= 20});
    end
    chk("seq_cnt", change_count, cnt_one);

    // second request mid-sequence is dropped
    req(5'd7, 1'b1, 5'd9);
    acks = 0;
    for (int k = 1; k <= 25; k++) begin
      if (k > 1) tick();
      if (k == 6) begin
        cfg_req = 1'b1; cfg_div = 5'd12; cfg_half = 1'b0; cfg_dly = 5'd1;
        tick(); k++;
        cfg_req = 1'b0;
      end
      if (cfg_ack) acks++;
      if (k == 21) chk("drop_ack_c21", {15'd0, cfg_ack}, 16'd1);
      chk($sformatf("drop_nack_c%0d", k), {15'd0, cfg_nack}, 16'd0);
    end
    chk("drop_ack_total", 16'(acks), 16'd1);
    chk("drop_odiv", {11'd0, odiv}, 16'd7);
    chk("drop_half", {15'd0, odivhalf}, 16'd1);
    chk("drop_dly", {11'd0, dlygl}, 16'd9);
    chk("drop_cnt", change_count, cnt_one << 1);

    // reset at cycle 10 of a sequence
    req(5'd3, 1'b0, 5'd4);
    for (int k = 2; k <= 10; k++) tick();
    chk("abort_pre_busy", {15'd0, busy}, 16'd1);
    reset = 1'b1;
    #1;
    chk("abort_odiv", {11'd0, odiv}, 16'd2);
    chk("abort_dly", {11'd0, dlygl}, 16'd0);
    chk("abort_divrst", {15'd0, div_reset}, 16'd1);
    chk("abort_ready", {15'd0, ready}, 16'd0);
    chk("abort_busy", {15'd0, busy}, 16'd1);
    chk("abort_ack", {14'd0, cfg_ack, cfg_nack}, 16'd0);
    chk("abort_cnt", change_count, 16'd0);
    tick();
    reset = 1'b0;
    chk_init();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/clk_div_ctrl.md
CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 Parameter HOLD_CYCLES, default 4, is the number of cycles div_reset is held high per reconfiguration; legal range >=1.
REQ-002 Parameter SETTLE_CYCLES, default 16, is the number of cycles waited after div_reset release before the controller reports ready; legal range >=1.
REQ-003 Parameter RESET_DIV, default 5'd2, is the odiv value driven from reset.
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-005 clk  in  1  single system clock, from the fabric clock module output.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 cfg_req  in  1  one-cycle configuration request strobe.
REQ-008 cfg_div  in  5  requested divider select.
REQ-009 cfg_half  in  1  requested half-step divide enable.
REQ-010 cfg_dly  in  5  requested global-clock delay select.
REQ-011 cfg_ack  out  1  one-cycle pulse: request completed.
REQ-012 cfg_nack  out  1  one-cycle pulse: request rejected.
REQ-013 busy  out  1  high while a sequence is in progress.
REQ-014 div_reset  out  1  reset to the clock divider primitive.
REQ-015 odiv  out  5  divider select to the primitive (ODIV4..0).
REQ-016 odivhalf  out  1  half-step select to the primitive.
REQ-017 dlygl  out  5  delay select to the primitive (DLYGL4..0).
REQ-018 ready  out  1  divided clock stable.
REQ-019 change_count  out  16  count of applied configuration changes.

Function
REQ-020 The FSM SHALL have states INIT, IDLE, HOLD, SETTLE.
REQ-021 INIT: ready=0 and busy=1; the FSM SHALL count SETTLE_CYCLES, then enter IDLE with ready=1 and no ack.
REQ-022 cfg_req SHALL be sampled only in IDLE; requests arriving in any other state are dropped, with no ack or nack.
REQ-023 A request with cfg_half=1 and cfg_div<2 is invalid; the block SHALL pulse cfg_nack on the next cycle and stay in IDLE with outputs unchanged.
REQ-024 A valid request equal to the current {odiv,odivhalf,dlygl} SHALL pulse cfg_ack on the next cycle, with no sequence and no count change.
REQ-025 For a valid, differing request sampled at cycle 0:
- the block SHALL latch the request into odiv/odivhalf/dlygl at the cycle 1 edge;
- div_reset=1 and ready=0 SHALL hold for cycles 1..HOLD_CYCLES (HOLD state);
- SETTLE SHALL span cycles HOLD_CYCLES+1..HOLD_CYCLES+SETTLE_CYCLES;
- cfg_ack and ready=1 SHALL assert at cycle HOLD_CYCLES+SETTLE_CYCLES+1.
REQ-026 busy SHALL be high in INIT, HOLD and SETTLE, and low in IDLE.
REQ-027 cfg_ack and cfg_nack SHALL never assert in the same cycle.
REQ-028 The HOLD and SETTLE counters SHALL be $clog2(max)+1 bits wide, count down to zero and reload on every state entry.
REQ-029 change_count SHALL increment by 1 at each ack of a differing config and saturate at 16'hFFFF.

Reset
REQ-030 During reset the outputs SHALL be:
- state=INIT, odiv=RESET_DIV, odivhalf=0, dlygl=0;
- div_reset=1, ready=0, busy=1;
- cfg_ack=0, cfg_nack=0, change_count=0.
REQ-031 Reset asserted mid-sequence SHALL abort it immediately, with no ack; after release, INIT SHALL run.
REQ-032 div_reset SHALL deassert on the first clk edge after reset release.

Configuration
REQ-033 With CLK_DIV_CTRL_CHANGE_CNT_EN defined, the change_count counter SHALL be implemented per REQ-029.
REQ-034 Without CLK_DIV_CTRL_CHANGE_CNT_EN, change_count SHALL be tied to 16'h0000 and no counter logic SHALL be present.

Structure
REQ-035 A shared package clk_div_pkg SHALL hold:
- the FSM state encoding;
- the 5-bit divider and delay field widths;
- the RESET_DIV default.
REQ-036 One sub-module, clk_div_cnt (loadable down-counter with zero flag), SHALL be instantiated for both the HOLD and SETTLE timing.

Verification
REQ-037 Reset release with defaults: odiv=2 at once; ready rises 16 cycles after the first edge; no cfg_ack.
REQ-038 In IDLE, request div=5, half=0, dly=3 at cycle 0:
- div_reset high cycles 1-4;
- ready low cycles 1-20;
- cfg_ack at cycle 21;
- change_count=1.
REQ-039 Request div=1, half=1: cfg_nack at cycle 1; odiv stays 2; busy stays 0.
REQ-040 Request of the current config (div=2, half=0, dly=0): cfg_ack at cycle 1; div_reset never asserts; change_count unchanged.
REQ-041 Second request at cycle 6 of a sequence: it is ignored and exactly one cfg_ack appears, at cycle 21.
REQ-042 Reset asserted at cycle 10 of a sequence:
- all outputs return to reset values at once;
- no ack;
- INIT runs again.
